idli_sqi_arb: RTL and testbench
===============================

Name: idli_sqi_arb

Overview:
- Shares the single SQI (quad-SPI) serial memory between the core's instruction-fetch port and its load/store port.
- Arbitrates between the two requests and runs the full SQI transaction: command, address, dummy and data nibbles.
- Returns 16-bit read data or completes 16-bit writes.
- Sits between idli core and the top-level uio pins; owns SCK, CS and the 4-bit data pads.

Parameters:
- ADDR_NIBBLES, 6, byte-address length in nibbles (24-bit address for 23LC1024-class parts).
- DUMMY_NIBBLES, 2, read dummy slots between address and data.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_fetch_req  in  1  fetch read request, held until ack
- i_fetch_addr  in  16  fetch word address
- o_fetch_ack  out  1  one-cycle completion pulse
- o_fetch_data  out  16  fetch read data
- i_data_req  in  1  load/store request, held until ack
- i_data_we  in  1  1=write, 0=read
- i_data_addr  in  16  data word address
- i_data_wdata  in  16  write data
- o_data_ack  out  1  one-cycle completion pulse
- o_data_rdata  out  16  load read data
- o_sqi_sck  out  1  serial clock
- o_sqi_cs  out  1  chip select, active low
- o_sqi_data  out  4  nibble out
- o_sqi_oe  out  4  pad output enables
- i_sqi_data  in  4  nibble in
- o_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: all acks 0, o_sqi_cs 1, o_sqi_sck 0, o_sqi_oe 0, o_sqi_data 0, o_busy 0, read-data regs 0. State is IDLE.
- Reset mid-transaction aborts immediately: CS deasserts, no ack is issued.
- States: IDLE -> CMD -> ADDR -> (read: DUMMY -> RDATA | write: WDATA) -> DESEL -> IDLE.
- Grant happens in IDLE on any request.
  - Fixed priority: data beats fetch.
  - At grant, capture address, we and wdata. Fetch is always a read.
  - Requester inputs are ignored after grant.
- Byte address = {zeros, word_addr, 1'b0}, width ADDR_NIBBLES*4. Shifted out MSB-first.
- Commands: READ 8'h03, WRITE 8'h02. Always 2 nibbles, MSB-first.
- Slot timing: every nibble slot is 2 cycles.
  - Phase 0: sck=0; o_sqi_data updates.
  - Phase 1: sck=1; in RDATA, i_sqi_data is captured at the clock edge ending phase 1.
- Slot counts: CMD 2, ADDR ADDR_NIBBLES, DUMMY DUMMY_NIBBLES, RDATA 4, WDATA 4. Read data is assembled MSB nibble first.
- o_sqi_oe: 4'hF in CMD/ADDR/WDATA; 4'h0 in IDLE/DUMMY/RDATA/DESEL.
- o_sqi_cs is 0 in CMD through the last data slot, and 1 otherwise.
- DESEL lasts 1 cycle: CS=1, sck=0, and the granted port's ack=1.
  - On a read, the rdata output updates at the same edge that raises ack. It holds until the next read on that port.
- Latency with default parameters (request first sampled in IDLE at cycle 0): read ack in cycle 29, write ack in cycle 25.
- Requester must drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- Back-to-back: minimum CS-high gap is 2 cycles (DESEL + IDLE grant).
- Counters: slot counter sized for max(ADDR_NIBBLES,4). No wrap beyond terminal count; it reloads on each state change.

Optional Feature:
- IDLI_SQI_ARB_RR_EN defined: round-robin arbitration.
  - On simultaneous requests, the port not granted last wins.
  - A last-grant flop updates at every grant; it resets to "fetch", so data wins the first tie.
- Undefined: fixed data>fetch priority, and no last-grant flop exists.

Decomposition:
- Package idli_sqi_pkg holds:
  - state enum
  - CMD_READ / CMD_WRITE constants
  - slot-phase encoding
  - port-select enum
- Sub-module idli_sqi_shift holds the 16/24-bit nibble shift register. It supports parallel load, shift-out of the MSB nibble, and shift-in at the LSB. One instance is shared between address and data phases.

Test Plan:
- Fetch read, addr 16'h0012, memory model returns 16'hBEEF -> nibbles out 0,3 / 0,0,0,0,2,4 with oe=F; then 2 dummy slots with oe=0; o_fetch_ack in cycle 29 with o_fetch_data=16'hBEEF; CS high for ≥2 cycles afterwards.
- Data write, addr 16'h8001, wdata 16'hA5C3 -> nibbles 0,2 / 0,1,0,0,0,2 / A,5,C,3; o_data_ack in cycle 25; o_fetch_ack stays 0.
- Fetch and data requests both raised in the same cycle -> data granted first; fetch acked after the data transaction plus one IDLE cycle. With RR_EN, a repeated tie alternates the grant.
- Reset asserted during the ADDR phase -> CS=1, oe=0, sck=0 within the same cycle (async); no ack. A re-issued request completes normally.
- Fetch req held continuously for 3 transactions -> 3 acks spaced 30 cycles apart; CS-high gap exactly 2 cycles each time.
- Read with i_sqi_data toggling in phase 0 only -> captured value reflects the phase-1 value, confirming the sample edge.

Source files
------------

// File: rtl/idli_sqi_pkg.sv
// Shared types and constants for the idli SQI arbiter and its shift register.
package idli_sqi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_DESEL
  } state_t;

  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  // Each nibble slot is two cycles: SCK low, then SCK high.
  typedef enum logic {
    PH_LOW  = 1'b0,
    PH_HIGH = 1'b1
  } phase_t;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_t;

  // Chip select is driven low in every state that owns a nibble slot.
  function automatic logic cs_active(input state_t s);
    return s inside {S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA};
  endfunction

endpackage

// File: rtl/idli_sqi_shift.sv
// Nibble shift register shared by the address, write-data and read-data slots.
// Shifts MSB nibble out while taking a new nibble in at the LSB.
module idli_sqi_shift #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift,
  input  logic [3:0]       din,
  output logic [3:0]       nib,
  output logic [15:0]      word
);

  logic [WIDTH-1:0] sr_reg;

  // Parallel load wins over shift so a phase hand-over can reload on its last edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= load_val;
    end else if (shift) begin
      sr_reg <= {sr_reg[WIDTH-5:0], din};
    end
  end

  assign nib  = sr_reg[WIDTH-1 -: 4];
  // Word as it will look once din is shifted in; used for the final read nibble.
  assign word = {sr_reg[11:0], din};

endmodule

// File: rtl/idli_sqi_arb.sv
// SQI memory arbiter: shares one quad-SPI part between fetch and load/store.
// Optional build macro: IDLI_SQI_ARB_RR_EN selects round-robin on ties
// (otherwise the data port always beats fetch).
module idli_sqi_arb
  import idli_sqi_pkg::*;
#(
  parameter int ADDR_NIBBLES  = 6,
  parameter int DUMMY_NIBBLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [15:0] i_fetch_addr,
  output logic        o_fetch_ack,
  output logic [15:0] o_fetch_data,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [15:0] i_data_addr,
  input  logic [15:0] i_data_wdata,
  output logic        o_data_ack,
  output logic [15:0] o_data_rdata,
  output logic        o_sqi_sck,
  output logic        o_sqi_cs,
  output logic [3:0]  o_sqi_data,
  output logic [3:0]  o_sqi_oe,
  input  logic [3:0]  i_sqi_data,
  output logic        o_busy
);

  localparam int ADDR_W      = ADDR_NIBBLES * 4;
  localparam int SH_W        = (ADDR_W > 16) ? ADDR_W : 16;
  localparam int MAX_SLOTS_A = (ADDR_NIBBLES > 4) ? ADDR_NIBBLES : 4;
  // Also wide enough for an unusually long dummy phase.
  localparam int MAX_SLOTS   = (DUMMY_NIBBLES > MAX_SLOTS_A) ? DUMMY_NIBBLES : MAX_SLOTS_A;
  localparam int CNT_W       = $clog2(MAX_SLOTS);

  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_NIBBLES - 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(3);
  localparam state_t AFTER_ADDR_RD = (DUMMY_NIBBLES == 0) ? S_RDATA : S_DUMMY;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  slot_reg, slot_next;
  phase_t            phase_reg, phase_next;
  port_t             port_reg, port_next;
  logic              we_reg, we_next;
  logic [15:0]       wdata_reg, wdata_next;
  logic [15:0]       fetch_data_reg, data_rdata_reg;

  port_t             sel;
  logic              grant;
  logic              slot_last;
  logic              rd_done;
  logic              sh_load, sh_shift;
  logic [SH_W-1:0]   sh_load_val;
  logic [3:0]        sh_nib;
  logic [15:0]       sh_word;
  logic [15:0]       grant_addr;
  logic [ADDR_W-1:0] byte_addr;
  logic [7:0]        cmd;

`ifdef IDLI_SQI_ARB_RR_EN
  port_t last_reg;

  // Round-robin select: on a tie the port not granted last wins.
  always_comb begin
    sel = PORT_FETCH;
    if (i_data_req && i_fetch_req) begin
      sel = (last_reg == PORT_FETCH) ? PORT_DATA : PORT_FETCH;
    end else if (i_data_req) begin
      sel = PORT_DATA;
    end
  end

  // Remember the last granted port; starts at fetch so data wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_reg <= PORT_FETCH;
    end else if (grant) begin
      last_reg <= sel;
    end
  end
`else
  assign sel = i_data_req ? PORT_DATA : PORT_FETCH;
`endif

  assign grant_addr = (sel == PORT_DATA) ? i_data_addr : i_fetch_addr;
  assign byte_addr  = ADDR_W'({grant_addr, 1'b0});
  assign cmd        = we_reg ? CMD_WRITE : CMD_READ;

  idli_sqi_shift #(.WIDTH(SH_W)) u_shift (
    .clk      (i_clk),
    .rst      (i_rst),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .din      (i_sqi_data),
    .nib      (sh_nib),
    .word     (sh_word)
  );

  // State, slot counter and captured request registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= S_IDLE;
      slot_reg  <= '0;
      phase_reg <= PH_LOW;
      port_reg  <= PORT_FETCH;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      phase_reg <= phase_next;
      port_reg  <= port_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
    end
  end

  // Next-state: grant in IDLE, then walk the nibble slots of each phase.
  always_comb begin
    state_next  = state_reg;
    slot_next   = slot_reg;
    phase_next  = phase_reg;
    port_next   = port_reg;
    we_next     = we_reg;
    wdata_next  = wdata_reg;
    grant       = 1'b0;
    sh_load     = 1'b0;
    sh_load_val = '0;
    sh_shift    = 1'b0;
    rd_done     = 1'b0;
    slot_last   = 1'b0;
    case (state_reg)
      S_CMD:            slot_last = (slot_reg == LAST_CMD);
      S_ADDR:           slot_last = (slot_reg == LAST_ADDR);
      S_DUMMY:          slot_last = (slot_reg == LAST_DUMMY);
      S_RDATA, S_WDATA: slot_last = (slot_reg == LAST_DATA);
      default:          slot_last = 1'b0;
    endcase

    if (state_reg == S_IDLE) begin
      if (i_data_req || i_fetch_req) begin
        grant       = 1'b1;
        port_next   = sel;
        we_next     = (sel == PORT_DATA) && i_data_we;
        wdata_next  = i_data_wdata;
        state_next  = S_CMD;
        slot_next   = '0;
        phase_next  = PH_LOW;
        sh_load     = 1'b1;
        sh_load_val = SH_W'(byte_addr) << (SH_W - ADDR_W);
      end
    end else if (state_reg == S_DESEL) begin
      state_next = S_IDLE;
    end else begin
      phase_next = (phase_reg == PH_LOW) ? PH_HIGH : PH_LOW;
      if (phase_reg == PH_HIGH) begin
        sh_shift = state_reg inside {S_ADDR, S_WDATA, S_RDATA};
        if (slot_last) begin
          slot_next = '0;
          case (state_reg)
            S_CMD:   state_next = S_ADDR;
            S_ADDR: begin
              if (we_reg) begin
                state_next  = S_WDATA;
                sh_load     = 1'b1;
                sh_load_val = SH_W'(wdata_reg) << (SH_W - 16);
              end else begin
                state_next = AFTER_ADDR_RD;
              end
            end
            S_DUMMY: state_next = S_RDATA;
            S_RDATA: begin
              state_next = S_DESEL;
              rd_done    = 1'b1;
            end
            default: state_next = S_DESEL;
          endcase
        end else begin
          slot_next = slot_reg + CNT_W'(1);
        end
      end
    end
  end

  // Pad drive: only command, address and write-data slots own the bus.
  always_comb begin
    o_sqi_data = 4'h0;
    o_sqi_oe   = 4'h0;
    case (state_reg)
      S_CMD: begin
        o_sqi_oe   = 4'hF;
        o_sqi_data = (slot_reg == '0) ? cmd[7:4] : cmd[3:0];
      end
      S_ADDR, S_WDATA: begin
        o_sqi_oe   = 4'hF;
        o_sqi_data = sh_nib;
      end
      default: begin
        o_sqi_data = 4'h0;
        o_sqi_oe   = 4'h0;
      end
    endcase
  end

  // Read results land on the same edge that enters DESEL and raises ack.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_data_reg <= '0;
      data_rdata_reg <= '0;
    end else if (rd_done) begin
      if (port_reg == PORT_FETCH) begin
        fetch_data_reg <= sh_word;
      end else begin
        data_rdata_reg <= sh_word;
      end
    end
  end

  assign o_sqi_cs     = ~cs_active(state_reg);
  assign o_sqi_sck    = cs_active(state_reg) && (phase_reg == PH_HIGH);
  assign o_busy       = (state_reg != S_IDLE);
  assign o_fetch_ack  = (state_reg == S_DESEL) && (port_reg == PORT_FETCH);
  assign o_data_ack   = (state_reg == S_DESEL) && (port_reg == PORT_DATA);
  assign o_fetch_data = fetch_data_reg;
  assign o_data_rdata = data_rdata_reg;

endmodule

// File: tb/tb_idli_sqi_arb.sv
// Scoreboard bench for idli_sqi_arb: stimulus queues expected transactions,
// a negedge monitor checks pad traffic and acks as they appear.
module tb_idli_sqi_arb;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_fetch_req = 1'b0;
  logic [15:0] i_fetch_addr = 16'h0;
  logic        o_fetch_ack;
  logic [15:0] o_fetch_data;
  logic        i_data_req = 1'b0;
  logic        i_data_we = 1'b0;
  logic [15:0] i_data_addr = 16'h0;
  logic [15:0] i_data_wdata = 16'h0;
  logic        o_data_ack;
  logic [15:0] o_data_rdata;
  logic        o_sqi_sck;
  logic        o_sqi_cs;
  logic [3:0]  o_sqi_data;
  logic [3:0]  o_sqi_oe;
  logic [3:0]  i_sqi_data = 4'h0;
  logic        o_busy;

  idli_sqi_arb dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_fetch_req  (i_fetch_req),
    .i_fetch_addr (i_fetch_addr),
    .o_fetch_ack  (o_fetch_ack),
    .o_fetch_data (o_fetch_data),
    .i_data_req   (i_data_req),
    .i_data_we    (i_data_we),
    .i_data_addr  (i_data_addr),
    .i_data_wdata (i_data_wdata),
    .o_data_ack   (o_data_ack),
    .o_data_rdata (o_data_rdata),
    .o_sqi_sck    (o_sqi_sck),
    .o_sqi_cs     (o_sqi_cs),
    .o_sqi_data   (o_sqi_data),
    .o_sqi_oe     (o_sqi_oe),
    .i_sqi_data   (i_sqi_data),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  typedef struct {
    logic        port;   // 0 fetch, 1 data
    logic        rd;
    logic [15:0] data;
    int          cyc;
    logic [63:0] nibs;
    int          nn;
    int          slots;
    int          gap;    // -1: gap not checked
  } exp_t;

  exp_t exp_q[$];

  task automatic expect_txn(input logic port, input logic rd, input logic [15:0] data,
                            input int c, input logic [63:0] nibs, input int nn, input int gap);
    exp_t e;
    e.port  = port;
    e.rd    = rd;
    e.data  = data;
    e.cyc   = c;
    e.nibs  = nibs;
    e.nn    = nn;
    e.slots = rd ? 14 : 12;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // Memory model: returns mem_word in read-data slots 10..13 (after cmd, addr, dummy).
  // During SCK-low the pins carry the inverted nibble, so only the SCK-high value is valid.
  logic [15:0] mem_word = 16'h0;
  int drv_sl = 0;

  function automatic logic [3:0] rd_nib(input int k);
    logic [15:0] t;
    if (k >= 10 && k <= 13) begin
      t = mem_word >> (4 * (13 - k));
      return t[3:0];
    end
    return 4'h0;
  endfunction

  always @(negedge i_clk) begin
    if (o_sqi_cs) begin
      drv_sl = 0;
      i_sqi_data = 4'h0;
    end else if (o_sqi_sck) begin
      i_sqi_data = rd_nib(drv_sl);
      drv_sl++;
    end else begin
      i_sqi_data = ~rd_nib(drv_sl);
    end
  end

  // Monitor: collect driven nibbles per CS window, check each ack against the queue.
  logic [63:0] cap_v = '0;
  int          cap_n = 0;
  int          nslots = 0;
  int          gap_cnt = 0;
  int          last_gap = 0;
  logic        cs_prev = 1'b1;
  exp_t        mon_e;

  always @(negedge i_clk) begin
    if (i_rst) begin
      cs_prev = 1'b1;
    end else begin
      if (!o_sqi_cs && cs_prev) begin
        last_gap = gap_cnt;
        gap_cnt  = 0;
        cap_v    = '0;
        cap_n    = 0;
        nslots   = 0;
      end
      if (o_sqi_cs) gap_cnt++;
      if (!o_sqi_cs && o_sqi_sck) begin
        nslots++;
        if (o_sqi_oe == 4'hF) begin
          cap_v = {cap_v[59:0], o_sqi_data};
          cap_n++;
        end
      end
      cs_prev = o_sqi_cs;
      if (o_fetch_ack || o_data_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 64'({o_data_ack, o_fetch_ack}), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_port", 64'({o_data_ack, o_fetch_ack}), mon_e.port ? 64'd2 : 64'd1);
          chk("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("nibbles", cap_v, mon_e.nibs);
          chk("nibble_count", 64'(cap_n), 64'(mon_e.nn));
          chk("slot_count", 64'(nslots), 64'(mon_e.slots));
          if (mon_e.rd) begin
            chk("rdata", 64'(mon_e.port ? o_data_rdata : o_fetch_data), 64'(mon_e.data));
          end
          if (mon_e.gap >= 0) chk("cs_gap", 64'(last_gap), 64'(mon_e.gap));
          $display("txn port=%s rd=%0d cyc=%0d nibs=%h data=%h",
                   mon_e.port ? "data" : "fetch", mon_e.rd, cyc, cap_v,
                   mon_e.port ? o_data_rdata : o_fetch_data);
        end
      end
    end
  end

  task automatic wait_ack(input logic port, input int maxc);
    int n = 0;
    logic a;
    do begin
      @(negedge i_clk);
      n++;
      a = port ? o_data_ack : o_fetch_ack;
    end while (!a && n < maxc);
    if (!a) chk(port ? "data_ack_timeout" : "fetch_ack_timeout", 64'(a), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int c0;

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_cs", 64'(o_sqi_cs), 64'd1);
    chk("rst_sck", 64'(o_sqi_sck), 64'd0);
    chk("rst_oe", 64'(o_sqi_oe), 64'd0);
    chk("rst_data", 64'(o_sqi_data), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_fetch_ack", 64'(o_fetch_ack), 64'd0);
    chk("rst_data_ack", 64'(o_data_ack), 64'd0);
    chk("rst_fetch_data", 64'(o_fetch_data), 64'd0);
    chk("rst_data_rdata", 64'(o_data_rdata), 64'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);

    // Data write 0x8001 <- A5C3: cmd 02, byte addr 010002, data A5C3; ack at +25.
    @(posedge i_clk); #1;
    c0 = cyc;
    i_data_addr = 16'h8001; i_data_wdata = 16'hA5C3; i_data_we = 1'b1; i_data_req = 1'b1;
    expect_txn(1'b1, 1'b0, 16'h0, c0 + 25, 64'h02010002A5C3, 12, -1);
    wait_ack(1'b1, 40);
    @(posedge i_clk); #1 i_data_req = 1'b0; i_data_we = 1'b0;
    repeat (3) @(posedge i_clk);

    // Data read 0xFFFF: byte addr 01FFFE, memory 8421; ack at +29.
    @(posedge i_clk); #1;
    c0 = cyc;
    mem_word = 16'h8421;
    i_data_addr = 16'hFFFF; i_data_req = 1'b1;
    expect_txn(1'b1, 1'b1, 16'h8421, c0 + 29, 64'h0301FFFE, 8, -1);
    wait_ack(1'b1, 40);
    @(posedge i_clk); #1 i_data_req = 1'b0;
    chk("fetch_data_untouched", 64'(o_fetch_data), 64'd0);
    repeat (3) @(posedge i_clk);

    // Fetch read 0x0012: byte addr 000024, memory BEEF; ack at +29.
    @(posedge i_clk); #1;
    c0 = cyc;
    mem_word = 16'hBEEF;
    i_fetch_addr = 16'h0012; i_fetch_req = 1'b1;
    expect_txn(1'b0, 1'b1, 16'hBEEF, c0 + 29, 64'h03000024, 8, -1);
    wait_ack(1'b0, 40);
    @(posedge i_clk); #1 i_fetch_req = 1'b0;
    chk("data_rdata_held", 64'(o_data_rdata), 64'h8421);
    repeat (3) @(posedge i_clk);

    // Tie: data write 0x0003 <- 1234 first, fetch 0x00F0 granted in the next IDLE.
    @(posedge i_clk); #1;
    c0 = cyc;
    mem_word = 16'hC0DE;
    i_data_addr = 16'h0003; i_data_wdata = 16'h1234; i_data_we = 1'b1; i_data_req = 1'b1;
    i_fetch_addr = 16'h00F0; i_fetch_req = 1'b1;
    expect_txn(1'b1, 1'b0, 16'h0, c0 + 25, 64'h020000061234, 12, -1);
    expect_txn(1'b0, 1'b1, 16'hC0DE, c0 + 55, 64'h030001E0, 8, 2);
    wait_ack(1'b1, 40);
    @(posedge i_clk); #1 i_data_req = 1'b0; i_data_we = 1'b0;
    wait_ack(1'b0, 40);
    @(posedge i_clk); #1 i_fetch_req = 1'b0;
    repeat (3) @(posedge i_clk);

    // Reset in the middle of the address phase (SCK high slot), no ack may follow.
    @(posedge i_clk); #1;
    c0 = cyc;
    i_fetch_addr = 16'h0100; i_fetch_req = 1'b1;
    repeat (8) @(posedge i_clk);
    #2;
    chk("pre_rst_sck", 64'(o_sqi_sck), 64'd1);
    chk("pre_rst_cs", 64'(o_sqi_cs), 64'd0);
    i_rst = 1'b1;
    #1;
    chk("mid_rst_cs", 64'(o_sqi_cs), 64'd1);
    chk("mid_rst_oe", 64'(o_sqi_oe), 64'd0);
    chk("mid_rst_sck", 64'(o_sqi_sck), 64'd0);
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    i_fetch_req = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (6) @(posedge i_clk);

    // Re-issued fetch 0x0100 completes normally: byte addr 000200, memory 0F0F.
    @(posedge i_clk); #1;
    c0 = cyc;
    mem_word = 16'h0F0F;
    i_fetch_req = 1'b1;
    expect_txn(1'b0, 1'b1, 16'h0F0F, c0 + 29, 64'h03000200, 8, -1);
    wait_ack(1'b0, 40);
    @(posedge i_clk); #1 i_fetch_req = 1'b0;
    repeat (3) @(posedge i_clk);

    // Fetch 0x7FFF held for three transactions: acks 30 apart, CS gap of 2.
    @(posedge i_clk); #1;
    c0 = cyc;
    mem_word = 16'h1357;
    i_fetch_addr = 16'h7FFF; i_fetch_req = 1'b1;
    expect_txn(1'b0, 1'b1, 16'h1357, c0 + 29, 64'h0300FFFE, 8, -1);
    expect_txn(1'b0, 1'b1, 16'h1357, c0 + 59, 64'h0300FFFE, 8, 2);
    expect_txn(1'b0, 1'b1, 16'h1357, c0 + 89, 64'h0300FFFE, 8, 2);
    wait_ack(1'b0, 40);
    wait_ack(1'b0, 40);
    wait_ack(1'b0, 40);
    @(posedge i_clk); #1 i_fetch_req = 1'b0;
    repeat (5) @(posedge i_clk);

    chk("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
